// File: rtl/conv_out_collector.sv
// Collects the y stream from the last PE: drops warm-up samples, applies the output stride,
// saturates to OUT_W and buffers kept results in a small FIFO with end-of-frame tagging.
module conv_out_collector #(
    parameter int unsigned ACC_W      = 32,
    parameter int unsigned OUT_W      = 16,
    parameter int unsigned TAPS       = 3,
    parameter int unsigned FRAME_LEN  = 64,
    parameter int unsigned STRIDE     = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             y_valid,
    input  logic [ACC_W-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int unsigned PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    // Sample index of the final kept result in a complete frame.
    localparam int unsigned KeepLastS = TAPS - 1 + ((FRAME_LEN - TAPS) / STRIDE) * STRIDE;

    typedef enum logic [1:0] {StIdle, StFill, StRun, StDrain} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   s_q, s_d, cur_s;
    logic [PW-1:0]   ph_q, ph_d, cur_ph;
    logic            start, take;
    logic            push, push_last, push_ok, pop;
    logic            empty, full;
    logic            overflow_q;
    logic [AW:0]     wr_q, rd_q;
    logic [OUT_W:0]  mem [FIFO_DEPTH];
    logic [OUT_W-1:0] sat_val;
    logic [ACC_W-OUT_W:0] upper;
    logic            sat_pos, sat_neg;

    // Saturation: in range iff all bits from the output sign bit upward agree.
    always_comb begin
        upper   = y_in[ACC_W-1:OUT_W-1];
        sat_pos = ~y_in[ACC_W-1] & (|upper);
        sat_neg = y_in[ACC_W-1] & ~(&upper);
        if (sat_pos) begin
            sat_val = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (sat_neg) begin
            sat_val = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            sat_val = y_in[OUT_W-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        ph_d      = ph_q;
        push      = 1'b0;
        push_last = 1'b0;
        start     = frame_start & y_valid;
        take      = start | (y_valid & ((state_q == StFill) | (state_q == StRun)));
        cur_s     = start ? '0 : s_q;
        cur_ph    = start ? '0 : ph_q;
        if (take) begin
            if (32'(cur_s) < TAPS - 1) begin
                state_d = (32'(cur_s) == TAPS - 2) ? StRun : StFill;
                s_d     = cur_s + CW'(1);
                ph_d    = '0;
            end else begin
                push      = (cur_ph == '0);
                push_last = push & (32'(cur_s) == KeepLastS);
                ph_d      = (32'(cur_ph) == STRIDE - 1) ? '0 : cur_ph + PW'(1);
                if (32'(cur_s) == FRAME_LEN - 1) begin
                    state_d = StDrain;
                end else begin
                    state_d = StRun;
                    s_d     = cur_s + CW'(1);
                end
            end
        end else if ((state_q == StDrain) && empty) begin
            state_d = StIdle;
        end
    end

    assign empty   = (wr_q == rd_q);
    assign full    = ((wr_q ^ rd_q) == {1'b1, {AW{1'b0}}});
    assign pop     = ~empty & out_ready;
    assign push_ok = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            s_q        <= '0;
            ph_q       <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            ph_q    <= ph_d;
            if (push_ok) begin
                wr_q <= wr_q + (AW+1)'(1);
            end
            if (pop) begin
                rd_q <= rd_q + (AW+1)'(1);
            end
            if (push & full & ~pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[wr_q[AW-1:0]] <= {push_last, sat_val};
        end
    end

    // Head is forced to zero when empty so outputs are clean after reset.
    always_comb begin
        out_valid = ~empty;
        out_data  = empty ? '0 : mem[rd_q[AW-1:0]][OUT_W-1:0];
        out_last  = empty ? 1'b0 : mem[rd_q[AW-1:0]][OUT_W];
        overflow  = overflow_q;
        busy      = (state_q != StIdle);
    end

endmodule
